// File: rtl/decoder_scan_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_scan_sequencer
//
// Upstream driver for a 2-to-4 decoder. Sweeps the decoder address A through
// 0..3, holding En high for a programmable dwell per slot, and separates
// consecutive slots with BLANK cycles of En low so the driven lines never
// ghost. Runs either one sweep (ending with a one-cycle done pulse) or scans
// continuously until stopped.
//
// Parameters
//   DWELL_W : width of the dwell input and of the dwell down-counter
//   BLANK   : En-low cycles between consecutive slots (0 = no gap)
//
// Ports
//   clk    in   1        rising-edge clock
//   rst    in   1        synchronous active-high reset, overrides start/stop
//   start  in   1        begin a sweep; only looked at while idle
//   stop   in   1        abort any sweep; stop beats start when both are high
//   mode   in   1        0 = single sweep, 1 = continuous; captured on start
//   dwell  in   DWELL_W  En-high cycles per slot; captured on start; 0 acts as 1
//   A      out  2        decoder address
//   En     out  1        decoder enable
//   busy   out  1        high while a sweep is running
//   done   out  1        one-cycle pulse after the last slot of a single sweep
//
// All outputs are registered; a start accepted at an edge shows A=0, En=1,
// busy=1 immediately after that same edge.
// -----------------------------------------------------------------------------
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int BLANK   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         A,
    output logic               En,
    output logic               busy,
    output logic               done
);

    // Gap counter must be able to hold BLANK; keep at least one bit so the
    // logic stays well formed when gaps are disabled.
    localparam int GAP_W = (BLANK < 1) ? 1 : $clog2(BLANK + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         a_nxt;
    logic               en_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [GAP_W-1:0]   gcnt;
    logic [GAP_W-1:0]   gcnt_nxt;
    logic               launch;

    // Sweep configuration captured when a start is accepted.
    logic               mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_eff;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Next-state and next-output logic. cnt holds the En-high cycles still
    // to go in the current slot including the present one, so the slot ends
    // when it reads 1. gcnt does the same for the blanking gap.
    always_comb begin
        state_nxt = state;
        a_nxt     = A;
        en_nxt    = En;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        cnt_nxt   = cnt;
        gcnt_nxt  = gcnt;
        launch    = 1'b0;

        if (stop) begin
            state_nxt = IDLE;
            a_nxt     = 2'd0;
            en_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    a_nxt    = 2'd0;
                    en_nxt   = 1'b0;
                    busy_nxt = 1'b0;
                    if (start) begin
                        launch    = 1'b1;
                        state_nxt = ACTIVE;
                        en_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                        cnt_nxt   = dwell_eff;
                    end
                end

                ACTIVE: begin
                    if (cnt > DWELL_W'(1)) begin
                        cnt_nxt = cnt - DWELL_W'(1);
                    end else if ((A != 2'd3) || mode_q) begin
                        if (BLANK > 0) begin
                            // A holds through the gap; it only advances
                            // while En is low.
                            state_nxt = GAP;
                            en_nxt    = 1'b0;
                            gcnt_nxt  = GAP_W'(BLANK);
                        end else begin
                            a_nxt   = A + 2'd1;
                            cnt_nxt = dwell_q;
                        end
                    end else begin
                        // Last slot of a single sweep: no trailing gap.
                        state_nxt = IDLE;
                        a_nxt     = 2'd0;
                        en_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end

                GAP: begin
                    if (gcnt > GAP_W'(1)) begin
                        gcnt_nxt = gcnt - GAP_W'(1);
                    end else begin
                        state_nxt = ACTIVE;
                        a_nxt     = A + 2'd1;   // wraps 3 -> 0 when scanning
                        en_nxt    = 1'b1;
                        cnt_nxt   = dwell_q;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    a_nxt     = 2'd0;
                    en_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            A     <= 2'd0;
            En    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_nxt;
            A     <= a_nxt;
            En    <= en_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            cnt   <= cnt_nxt;
            gcnt  <= gcnt_nxt;
        end
    end

    // Configuration is only consumed while a sweep runs, and a sweep can
    // only begin through launch, so these registers need no reset.
    always_ff @(posedge clk) begin
        if (launch && !rst) begin
            mode_q  <= mode;
            dwell_q <= dwell_eff;
        end
    end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
module tb_decoder_scan_sequencer;

    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [1:0] A;
    logic       En;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    decoder_scan_sequencer #(.DWELL_W(8), .BLANK(B)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .dwell(dwell), .A(A), .En(En), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {A, En, busy, done} t edges after the start edge (t=0 is the
    // state right after the edge that accepted start). Each slot occupies
    // d + B cycles: d with En high, then B blank cycles with A held.
    function automatic logic [4:0] model(int t, int d, bit cont);
        int p;
        int slot;
        int off;
        int len;
        p   = d + B;
        len = 4 * d + 3 * B;
        if (!cont && t == len) return 5'b00001;
        if (!cont && t > len)  return 5'b00000;
        slot = (t / p) % 4;
        off  = t % p;
        return {2'(slot), (off < d), 1'b1, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; dwell = 8'd3; mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({A, En, busy, done} !== 5'b00000) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%b exp=00000", i, {A, En, busy, done});
            end
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({A, En, busy, done} !== 5'b00000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=00000", i, {A, En, busy, done});
            end
        end
    endtask

    task automatic test_single_sweep();
        int d;
        int len;
        int busy_cnt;
        int done_cnt;
        for (int it = 0; it < 4; it++) begin
            d = (it == 0) ? 3 : int'($urandom_range(1, 6));
            len = 4 * d + 3 * B;
            busy_cnt = 0; done_cnt = 0;
            dwell = 8'(d); mode = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            for (int t = 0; t <= len + 2; t++) begin
                checks++;
                if ({A, En, busy, done} !== model(t, d, 1'b0)) begin
                    failures++;
                    $display("FAIL single d=%0d t=%0d got=%b exp=%b", d, t,
                             {A, En, busy, done}, model(t, d, 1'b0));
                end
                if (busy === 1'b1) busy_cnt++;
                if (done === 1'b1) done_cnt++;
                tick();
            end
            checks++;
            if (busy_cnt != len || done_cnt != 1) begin
                failures++;
                $display("FAIL single_len d=%0d busy=%0d done=%0d exp busy=%0d done=1",
                         d, busy_cnt, done_cnt, len);
            end
        end
    endtask

    task automatic test_continuous();
        int d;
        int p;
        int done_cnt;
        d = 1; p = d + B; done_cnt = 0;
        dwell = 8'd1; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 3 * 4 * p + 3; t++) begin
            checks++;
            if ({A, En, busy, done} !== model(t, d, 1'b1)) begin
                failures++;
                $display("FAIL continuous t=%0d got=%b exp=%b", t,
                         {A, En, busy, done}, model(t, d, 1'b1));
            end
            if (done === 1'b1) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL continuous_done count=%0d exp=0", done_cnt);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({A, En, busy, done} !== 5'b00000) begin
            failures++;
            $display("FAIL continuous_stop got=%b exp=00000", {A, En, busy, done});
        end
    endtask

    task automatic test_stop();
        int d;
        int stop_t;
        bit cont;
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin
                d = 3; cont = 1'b0;
                stop_t = 2 * (d + B) + 1;   // second cycle of slot A=2
            end else begin
                d = int'($urandom_range(1, 5));
                cont = 1'($urandom_range(0, 1));
                stop_t = int'($urandom_range(0, 4 * d + 3 * B - 1));
            end
            dwell = 8'(d); mode = cont; start = 1'b1;
            tick();
            start = 1'b0;
            for (int t = 0; t <= stop_t; t++) begin
                checks++;
                if ({A, En, busy, done} !== model(t, d, cont)) begin
                    failures++;
                    $display("FAIL stop_run d=%0d t=%0d got=%b exp=%b", d, t,
                             {A, En, busy, done}, model(t, d, cont));
                end
                if (t == stop_t) stop = 1'b1;
                tick();
                stop = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({A, En, busy, done} !== 5'b00000) begin
                    failures++;
                    $display("FAIL stop_idle d=%0d at=%0d cyc=%0d got=%b exp=00000",
                             d, stop_t, i, {A, En, busy, done});
                end
                tick();
            end
        end
    endtask

    task automatic test_dwell_zero_and_ignore();
        int len;
        len = 4 * 1 + 3 * B;
        dwell = 8'd0; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= len + 2; t++) begin
            checks++;
            if ({A, En, busy, done} !== model(t, 1, 1'b0)) begin
                failures++;
                $display("FAIL ignore t=%0d got=%b exp=%b", t,
                         {A, En, busy, done}, model(t, 1, 1'b0));
            end
            // Mid-sweep start, dwell and mode changes must all be ignored.
            if (t == 2) begin start = 1'b1; dwell = 8'd5; mode = 1'b1; end
            if (t == 4) start = 1'b0;
            tick();
        end
        mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        int d1;
        int d2;
        int l1;
        int l2;
        d1 = int'($urandom_range(1, 4));
        d2 = int'($urandom_range(1, 4));
        l1 = 4 * d1 + 3 * B;
        l2 = 4 * d2 + 3 * B;
        dwell = 8'(d1); mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= l1; t++) begin
            checks++;
            if ({A, En, busy, done} !== model(t, d1, 1'b0)) begin
                failures++;
                $display("FAIL b2b_first d=%0d t=%0d got=%b exp=%b", d1, t,
                         {A, En, busy, done}, model(t, d1, 1'b0));
            end
            if (t == l1) begin start = 1'b1; dwell = 8'(d2); end
            tick();
        end
        start = 1'b0;
        for (int t = 0; t <= l2 + 1; t++) begin
            checks++;
            if ({A, En, busy, done} !== model(t, d2, 1'b0)) begin
                failures++;
                $display("FAIL b2b_second d=%0d t=%0d got=%b exp=%b", d2, t,
                         {A, En, busy, done}, model(t, d2, 1'b0));
            end
            tick();
        end
    endtask

    task automatic test_rst_gap_and_start_stop();
        dwell = 8'd2; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 2; t++) begin
            checks++;
            if ({A, En, busy, done} !== model(t, 2, 1'b1)) begin
                failures++;
                $display("FAIL rstgap_run t=%0d got=%b exp=%b", t,
                         {A, En, busy, done}, model(t, 2, 1'b1));
            end
            if (t < 2) tick();
        end
        // t=2 is the first blank cycle; reset there with start held high.
        rst = 1'b1; start = 1'b1;
        tick();
        checks++;
        if ({A, En, busy, done} !== 5'b00000) begin
            failures++;
            $display("FAIL rst_in_gap got=%b exp=00000", {A, En, busy, done});
        end
        rst = 1'b0; start = 1'b0;
        tick();
        checks++;
        if ({A, En, busy, done} !== 5'b00000) begin
            failures++;
            $display("FAIL rst_after_gap got=%b exp=00000", {A, En, busy, done});
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({A, En, busy, done} !== 5'b00000) begin
                failures++;
                $display("FAIL start_stop_idle cyc=%0d got=%b exp=00000", i, {A, En, busy, done});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_continuous();
        test_stop();
        test_dwell_zero_and_ignore();
        test_back_to_back();
        test_rst_gap_and_start_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
